// File: rtl/entry_alloc_ctrl.sv
// Entry allocator for an N-entry window (RS / ROB / LSQ slots).
// One lowest-index grant and one release per cycle; flush frees all entries.

// Recursive halving first-one search: the lower half wins whenever it holds a set bit.
module entry_alloc_ffs #(
    parameter int W  = 16,
    parameter int LW = $clog2(W)
) (
    input  logic [W-1:0]  bits,
    output logic          valid,
    output logic [LW-1:0] idx
);

    generate
        if (W == 2) begin : g_leaf
            assign valid = |bits;
            assign idx   = ~bits[0];
        end else begin : g_split
            logic          lo_valid;
            logic          hi_valid;
            logic [LW-2:0] lo_idx;
            logic [LW-2:0] hi_idx;

            entry_alloc_ffs #(
                .W (W / 2)
            ) u_lo (
                .bits  (bits[W/2-1:0]),
                .valid (lo_valid),
                .idx   (lo_idx)
            );

            entry_alloc_ffs #(
                .W (W / 2)
            ) u_hi (
                .bits  (bits[W-1:W/2]),
                .valid (hi_valid),
                .idx   (hi_idx)
            );

            assign valid = lo_valid | hi_valid;
            assign idx   = lo_valid ? {1'b0, lo_idx} : {1'b1, hi_idx};
        end
    endgenerate

endmodule

module entry_alloc_ctrl #(
    parameter int ENTRY_NUM = 16,
    parameter int IDX_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_req,
    output logic                 alloc_gnt,
    output logic [IDX_WIDTH-1:0] alloc_idx,
    input  logic                 rel_valid,
    input  logic [IDX_WIDTH-1:0] rel_idx,
    input  logic                 flush,
    output logic [IDX_WIDTH:0]   free_cnt,
    output logic                 full,
    output logic                 empty,
    output logic                 rel_err
);

    localparam logic [IDX_WIDTH:0] CNT_MAX = (IDX_WIDTH + 1)'(ENTRY_NUM);

    // 1 = entry is free
    logic [ENTRY_NUM-1:0] free_map;
    logic [ENTRY_NUM-1:0] free_map_nxt;
    logic [ENTRY_NUM-1:0] gnt_mask;
    logic [ENTRY_NUM-1:0] rel_mask;
    logic [IDX_WIDTH:0]   cnt_nxt;
    logic                 full_nxt;
    logic                 empty_nxt;
    logic                 err_nxt;
    logic                 any_free;
    logic [IDX_WIDTH-1:0] first_idx;
    logic                 rel_live;
    logic                 rel_hit;
    logic                 rel_dup;

    entry_alloc_ffs #(
        .W  (ENTRY_NUM),
        .LW (IDX_WIDTH)
    ) u_ffs (
        .bits  (free_map),
        .valid (any_free),
        .idx   (first_idx)
    );

    // Zero-latency grant from the registered map; flush and reset suppress it
    always_comb begin
        alloc_gnt = alloc_req & any_free & ~flush & ~rst;
        alloc_idx = alloc_gnt ? first_idx : '0;
    end

    // Classify a release as a real free or a double release of a free entry
    always_comb begin
        rel_live = rel_valid & ~flush & ~rst;
        rel_hit  = rel_live & ~free_map[rel_idx];
        rel_dup  = rel_live & free_map[rel_idx];
    end

    // One-hot update masks; a real release can never hit the granted index
    always_comb begin
        gnt_mask = '0;
        rel_mask = '0;
        if (alloc_gnt) begin
            gnt_mask[alloc_idx] = 1'b1;
        end
        if (rel_hit) begin
            rel_mask[rel_idx] = 1'b1;
        end
    end

    // Next map and count; flush frees everything and drops concurrent traffic
    always_comb begin
        free_map_nxt = (free_map & ~gnt_mask) | rel_mask;
        cnt_nxt      = free_cnt
                     + (IDX_WIDTH + 1)'(rel_hit)
                     - (IDX_WIDTH + 1)'(alloc_gnt);
        if (flush) begin
            free_map_nxt = '1;
            cnt_nxt      = CNT_MAX;
        end
    end

    // Status flags derived from the next-state count so they track free_cnt
    always_comb begin
        full_nxt  = (cnt_nxt == '0);
        empty_nxt = (cnt_nxt == CNT_MAX);
        err_nxt   = rel_err | rel_dup;
    end

    // State register with synchronous reset; rel_err survives flush
    always_ff @(posedge clk) begin
        if (rst) begin
            free_map <= '1;
            free_cnt <= CNT_MAX;
            full     <= 1'b0;
            empty    <= 1'b1;
            rel_err  <= 1'b0;
        end else begin
            free_map <= free_map_nxt;
            free_cnt <= cnt_nxt;
            full     <= full_nxt;
            empty    <= empty_nxt;
            rel_err  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_entry_alloc_ctrl.sv
// Directed, table-driven bench for entry_alloc_ctrl.
// Each row: inputs, expected grant before the edge, expected state after it.

module tb_entry_alloc_ctrl;

    logic       clk;
    logic       rst;
    logic       alloc_req;
    logic       alloc_gnt;
    logic [3:0] alloc_idx;
    logic       rel_valid;
    logic [3:0] rel_idx;
    logic       flush;
    logic [4:0] free_cnt;
    logic       full;
    logic       empty;
    logic       rel_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] model_map;

    typedef struct {
        logic       rst;
        logic       req;
        logic       rv;
        logic [3:0] ri;
        logic       fl;
        logic       eg;
        logic [3:0] ei;
        logic [4:0] ec;
        logic       ef;
        logic       ee;
        logic       er;
    } vec_t;

    vec_t vq[$];

    entry_alloc_ctrl #(
        .ENTRY_NUM (16),
        .IDX_WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alloc_req (alloc_req),
        .alloc_gnt (alloc_gnt),
        .alloc_idx (alloc_idx),
        .rel_valid (rel_valid),
        .rel_idx   (rel_idx),
        .flush     (flush),
        .free_cnt  (free_cnt),
        .full      (full),
        .empty     (empty),
        .rel_err   (rel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int n,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h",
                     name, n, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic q, input logic v,
                       input logic [3:0] i, input logic f,
                       input logic g, input logic [3:0] gi,
                       input logic [4:0] c, input logic fu,
                       input logic em, input logic e);
        vec_t t;
        t.rst = r; t.req = q; t.rv = v; t.ri = i; t.fl = f;
        t.eg = g; t.ei = gi; t.ec = c; t.ef = fu; t.ee = em; t.er = e;
        vq.push_back(t);
    endtask

    // Independent view of the free map, used for the popcount invariant
    task automatic model_step(input vec_t t);
        logic [15:0] pre;
        pre = model_map;
        if (t.rst || t.fl) begin
            model_map = '1;
        end else begin
            if (t.req) begin
                for (int b = 0; b < 16; b++) begin
                    if (pre[b]) begin
                        model_map[b] = 1'b0;
                        break;
                    end
                end
            end
            if (t.rv && !pre[t.ri]) model_map[t.ri] = 1'b1;
        end
    endtask

    task automatic run(input vec_t t, input int n);
        @(negedge clk);
        rst       = t.rst;
        alloc_req = t.req;
        rel_valid = t.rv;
        rel_idx   = t.ri;
        flush     = t.fl;
        #1;
        chk("alloc_gnt", n, 32'(alloc_gnt), 32'(t.eg));
        chk("alloc_idx", n, 32'(alloc_idx), 32'(t.ei));
        @(posedge clk);
        model_step(t);
        #1;
        chk("free_cnt", n, 32'(free_cnt), 32'(t.ec));
        chk("full", n, 32'(full), 32'(t.ef));
        chk("empty", n, 32'(empty), 32'(t.ee));
        chk("rel_err", n, 32'(rel_err), 32'(t.er));
        chk("free_map", n, 32'(dut.free_map), 32'(model_map));
        chk("popcount", n, 32'(free_cnt), 32'($countones(model_map)));
    endtask

    initial begin
        vec_t h;
        rst       = 1'b1;
        alloc_req = 1'b0;
        rel_valid = 1'b0;
        rel_idx   = '0;
        flush     = 1'b0;
        model_map = '1;

        // reset with a request pending: no grant
        add(1, 1, 0, 0, 0, 0, 0, 16, 0, 1, 0);
        // sixteen grants in index order
        for (int i = 0; i < 16; i++)
            add(0, 1, 0, 0, 0, 1, 4'(i), 5'(15 - i), (i == 15), 0, 0);
        // full: request refused
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // release 9 not visible until the next cycle
        add(0, 1, 1, 9, 0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 9, 0, 1, 0, 0);
        // free entries 1 and 2
        add(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 2, 0, 0, 0, 2, 0, 0, 0);
        // grant 1 while releasing 5: net count unchanged
        add(0, 1, 1, 5, 0, 1, 1, 2, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 2, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 5, 0, 1, 0, 0);
        // double release of 3
        add(0, 0, 1, 3, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 3, 0, 0, 0, 1, 0, 0, 1);
        // release of the index granted this cycle: grant wins
        add(0, 1, 1, 3, 0, 1, 3, 0, 1, 0, 1);
        // flush ignores request and release, keeps rel_err
        add(0, 1, 1, 4, 1, 0, 0, 16, 0, 1, 1);
        for (int i = 0; i < 10; i++)
            add(0, 1, 0, 0, 0, 1, 4'(i), 5'(15 - i), 0, 0, 1);
        add(0, 1, 1, 2, 1, 0, 0, 16, 0, 1, 1);
        add(0, 1, 0, 0, 0, 1, 0, 15, 0, 0, 1);
        add(0, 1, 0, 0, 0, 1, 1, 14, 0, 0, 1);
        // reset mid-stream clears rel_err
        add(1, 1, 0, 0, 0, 0, 0, 16, 0, 1, 0);
        add(0, 1, 0, 0, 0, 1, 0, 15, 0, 0, 0);
        add(0, 1, 1, 1, 0, 1, 1, 14, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 16, 0, 1, 0);
        // double release while empty: count stays at max
        add(0, 0, 1, 15, 0, 0, 0, 16, 0, 1, 1);

        foreach (vq[k]) run(vq[k], k);

        // rst held several cycles with a request: never a grant
        h = '{rst: 1, req: 1, rv: 0, ri: 0, fl: 0,
              eg: 0, ei: 0, ec: 16, ef: 0, ee: 1, er: 0};
        for (int k = 0; k < 3; k++) run(h, 100 + k);
        // first grants after reset start at 0 and climb
        for (int k = 0; k < 3; k++) begin
            h = '{rst: 0, req: 1, rv: 0, ri: 0, fl: 0,
                  eg: 1, ei: 4'(k), ec: 5'(15 - k),
                  ef: 0, ee: 0, er: 0};
            run(h, 200 + k);
        end
        // release 1 while requesting: 3 granted, 1 returns
        h = '{rst: 0, req: 1, rv: 1, ri: 1, fl: 0,
              eg: 1, ei: 3, ec: 13, ef: 0, ee: 0, er: 0};
        run(h, 300);
        h = '{rst: 0, req: 1, rv: 0, ri: 0, fl: 0,
              eg: 1, ei: 1, ec: 12, ef: 0, ee: 0, er: 0};
        run(h, 301);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
